// File: rtl/tdm_demux_if.sv
// Bus bundle for the TDM demultiplexer: serial sample input side and
// parallel frame output side.
interface tdm_demux_if #(
    parameter int NCH = 4,
    parameter int W   = 8
);
    logic [W-1:0]     in_data;
    logic             in_valid;
    logic             in_sof;
    logic [NCH*W-1:0] out_data;
    logic             out_valid;
    logic             frame_err;

    modport master (
        output in_data,
        output in_valid,
        output in_sof,
        input  out_data,
        input  out_valid,
        input  frame_err
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_sof,
        output out_data,
        output out_valid,
        output frame_err
    );
endinterface

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: collects NCH serial W-bit samples, aligned by
// sof on channel 0, and presents each completed frame in parallel.
module tdm_demux #(
    parameter int NCH = 4,
    parameter int W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    tdm_demux_if.slave  bus
);
    localparam int IW = $clog2(NCH);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

    typedef enum logic {
        HUNT,
        COLLECT
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [W-1:0]     stg_q [NCH];
    logic [W-1:0]     stg_d [NCH];
    logic [NCH*W-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             frame_err_q, frame_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                stg_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            for (int k = 0; k < NCH; k++) begin
                stg_q[k] <= stg_d[k];
            end
        end
    end

    // The final sample bypasses staging and goes straight into out_data, so a
    // new frame can start on the very next valid cycle.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        stg_d       = stg_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            HUNT: begin
                if (bus.in_valid && bus.in_sof) begin
                    stg_d[0] = bus.in_data;
                    idx_d    = IW'(1);
                    state_d  = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.in_valid) begin
                    if (bus.in_sof) begin
                        frame_err_d = 1'b1;
                        stg_d[0]    = bus.in_data;
                        idx_d       = IW'(1);
                    end else if (idx_q == LAST_IDX) begin
                        for (int k = 0; k < NCH - 1; k++) begin
                            out_data_d[k*W +: W] = stg_q[k];
                        end
                        out_data_d[(NCH-1)*W +: W] = bus.in_data;
                        out_valid_d = 1'b1;
                        idx_d       = '0;
                        state_d     = HUNT;
                    end else begin
                        stg_d[idx_q] = bus.in_data;
                        idx_d        = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = HUNT;
                idx_d   = '0;
            end
        endcase
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.frame_err = frame_err_q;
endmodule
